// File: rtl/router_pkg.sv
// Shared definitions for the 1x3 packet router datapath: byte width,
// header field layout and the reserved (invalid) destination address.
package router_pkg;

  localparam int BYTE_W = 8;
  localparam logic [1:0] ADDR_INVALID = 2'b11;

  // Header byte layout: {len[5:0], addr[1:0]}
  typedef struct packed {
    logic [5:0] len;
    logic [1:0] addr;
  } hdr_t;

  function automatic logic addr_is_valid(input logic [1:0] addr);
    return addr != ADDR_INVALID;
  endfunction

endpackage

// File: rtl/router_parity_chk.sv
// Running XOR parity over header and payload, capture of the trailing parity
// byte, and the parity_done / err flags derived from comparing the two.
import router_pkg::*;

module router_parity_chk (
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] data_in,
  input  logic [BYTE_W-1:0] hdr_byte,
  input  logic              packet_valid,
  input  logic              fifo_full,
  input  logic              detect_add,
  input  logic              ld_state,
  input  logic              laf_state,
  input  logic              full_state,
  input  logic              lfd_state,
  input  logic              low_packet_valid,
  output logic              parity_done,
  output logic              err
);

  logic [BYTE_W-1:0] int_parity;
  logic [BYTE_W-1:0] pkt_parity;

  // The trailing parity byte arrives with packet_valid low, so it is never
  // folded into int_parity; a byte stalled by full_state was already counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      int_parity <= '0;
    end else if (detect_add) begin
      int_parity <= '0;
    end else if (lfd_state) begin
      int_parity <= int_parity ^ hdr_byte;
    end else if (ld_state && packet_valid && !full_state) begin
      int_parity <= int_parity ^ data_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_parity <= '0;
    end else if (ld_state && !packet_valid) begin
      pkt_parity <= data_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_done <= 1'b0;
    end else if (detect_add) begin
      parity_done <= 1'b0;
    end else if ((ld_state && !fifo_full && !packet_valid) ||
                 (laf_state && low_packet_valid && !parity_done)) begin
      parity_done <= 1'b1;
    end
  end

  // err trails parity_done by one cycle so pkt_parity is already captured.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (detect_add) begin
      err <= 1'b0;
    end else if (parity_done) begin
      err <= (int_parity != pkt_parity);
    end
  end

endmodule

// File: rtl/router_reg.sv
// Router datapath register: latches the header, drives dout toward the
// selected FIFO, parks one byte while that FIFO is full, and checks parity.
import router_pkg::*;

module router_reg (
  input  logic              clk,
  input  logic              resetn,
  input  logic              packet_valid,
  input  logic [BYTE_W-1:0] data_in,
  input  logic              fifo_full,
  input  logic              detect_add,
  input  logic              ld_state,
  input  logic              laf_state,
  input  logic              full_state,
  input  logic              lfd_state,
  input  logic              rst_int_reg,
  output logic              err,
  output logic              parity_done,
  output logic              low_packet_valid,
  output logic [BYTE_W-1:0] dout
);

  logic [BYTE_W-1:0] hdr_byte;
  logic [BYTE_W-1:0] full_byte;

  // Reset input is active-high despite its name.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      hdr_byte <= '0;
    end else if (detect_add && packet_valid && addr_is_valid(data_in[1:0])) begin
      hdr_byte <= data_in;
    end
  end

  // With the FIFO full the incoming byte is parked in full_byte and replayed
  // from LOAD_AFTER_FULL; dout holds meanwhile.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      dout      <= '0;
      full_byte <= '0;
    end else if (lfd_state) begin
      dout <= hdr_byte;
    end else if (ld_state && !fifo_full) begin
      dout <= data_in;
    end else if (ld_state && fifo_full) begin
      full_byte <= data_in;
    end else if (laf_state) begin
      dout <= full_byte;
    end
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      low_packet_valid <= 1'b0;
    end else if (rst_int_reg) begin
      low_packet_valid <= 1'b0;
    end else if (ld_state && !packet_valid) begin
      low_packet_valid <= 1'b1;
    end
  end

  router_parity_chk u_parity_chk (
    .clk              (clk),
    .rst              (resetn),
    .data_in          (data_in),
    .hdr_byte         (hdr_byte),
    .packet_valid     (packet_valid),
    .fifo_full        (fifo_full),
    .detect_add       (detect_add),
    .ld_state         (ld_state),
    .laf_state        (laf_state),
    .full_state       (full_state),
    .lfd_state        (lfd_state),
    .low_packet_valid (low_packet_valid),
    .parity_done      (parity_done),
    .err              (err)
  );

endmodule

// File: tb/tb_router_reg.sv
// Directed bench for router_reg: expected dout bytes are queued as stimulus
// is driven and popped when the byte should appear on dout.
import router_pkg::*;

module tb_router_reg;

  logic              clk;
  logic              resetn;
  logic              packet_valid;
  logic [BYTE_W-1:0] data_in;
  logic              fifo_full;
  logic              detect_add;
  logic              ld_state;
  logic              laf_state;
  logic              full_state;
  logic              lfd_state;
  logic              rst_int_reg;
  logic              err;
  logic              parity_done;
  logic              low_packet_valid;
  logic [BYTE_W-1:0] dout;

  int errors = 0;
  int checks = 0;
  logic [BYTE_W-1:0] exp_q[$];
  logic [BYTE_W-1:0] model_hdr;

  router_reg dut (
    .clk              (clk),
    .resetn           (resetn),
    .packet_valid     (packet_valid),
    .data_in          (data_in),
    .fifo_full        (fifo_full),
    .detect_add       (detect_add),
    .ld_state         (ld_state),
    .laf_state        (laf_state),
    .full_state       (full_state),
    .lfd_state        (lfd_state),
    .rst_int_reg      (rst_int_reg),
    .err              (err),
    .parity_done      (parity_done),
    .low_packet_valid (low_packet_valid),
    .dout             (dout)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one rising edge; outputs are sampled 1 time unit later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_dout(input string tag);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=%0h expected=<empty queue>", tag, dout);
    end else begin
      e = exp_q.pop_front();
      chk(tag, dout, e);
    end
  endtask

  task automatic idle_inputs();
    packet_valid = 1'b0;
    data_in      = '0;
    fifo_full    = 1'b0;
    detect_add   = 1'b0;
    ld_state     = 1'b0;
    laf_state    = 1'b0;
    full_state   = 1'b0;
    lfd_state    = 1'b0;
    rst_int_reg  = 1'b0;
  endtask

  // One complete packet. stall_idx selects a payload byte (forced to 0xA5)
  // that meets a full FIFO; -1 means no stall.
  task automatic run_packet(input logic [7:0] hdr, input int n,
                            input logic [7:0] corrupt, input int stall_idx);
    logic [7:0] par;
    logic [7:0] last;
    logic [7:0] b;
    detect_add   = 1'b1;
    packet_valid = 1'b1;
    data_in      = hdr;
    tick();
    detect_add = 1'b0;
    if (hdr[1:0] != 2'b11) model_hdr = hdr;
    chk("err_cleared_by_detect", {7'b0, err}, 8'h00);
    chk("pdone_cleared_by_detect", {7'b0, parity_done}, 8'h00);

    par = model_hdr;
    lfd_state = 1'b1;
    data_in   = 8'($urandom_range(0, 255));
    exp_q.push_back(model_hdr);
    tick();
    lfd_state = 1'b0;
    chk_dout("dout_header");
    last = model_hdr;

    for (int i = 0; i < n; i++) begin
      b = (i == stall_idx) ? 8'hA5 : 8'($urandom_range(0, 255));
      par = par ^ b;
      ld_state = 1'b1;
      data_in  = b;
      if (i == stall_idx) begin
        fifo_full = 1'b1;
        tick();
        chk("dout_hold_ld_full", dout, last);
        ld_state   = 1'b0;
        full_state = 1'b1;
        tick();
        chk("dout_hold_full_state", dout, last);
        full_state = 1'b0;
        fifo_full  = 1'b0;
        laf_state  = 1'b1;
        exp_q.push_back(b);
        tick();
        laf_state = 1'b0;
        chk_dout("dout_after_laf");
      end else begin
        exp_q.push_back(b);
        tick();
        chk_dout("dout_payload");
      end
      last = b;
    end

    ld_state     = 1'b1;
    packet_valid = 1'b0;
    data_in      = par ^ corrupt;
    exp_q.push_back(par ^ corrupt);
    tick();
    ld_state = 1'b0;
    chk_dout("dout_parity");
    chk("pdone_on_parity_edge", {7'b0, parity_done}, 8'h01);
    chk("lpv_on_parity_edge", {7'b0, low_packet_valid}, 8'h01);
    last = par ^ corrupt;

    data_in = 8'($urandom_range(0, 255));
    tick();
    chk("err_after_pdone", {7'b0, err}, (corrupt != 0) ? 8'h01 : 8'h00);
    chk("lpv_holds", {7'b0, low_packet_valid}, 8'h01);
    chk("dout_idle_hold", dout, last);

    rst_int_reg = 1'b1;
    tick();
    rst_int_reg = 1'b0;
    chk("lpv_cleared", {7'b0, low_packet_valid}, 8'h00);
    chk("err_holds", {7'b0, err}, (corrupt != 0) ? 8'h01 : 8'h00);
  endtask

  initial begin
    idle_inputs();
    model_hdr = '0;
    resetn = 1'b1;
    tick();
    tick();
    chk("reset_dout", dout, 8'h00);
    chk("reset_err", {7'b0, err}, 8'h00);
    chk("reset_pdone", {7'b0, parity_done}, 8'h00);
    chk("reset_lpv", {7'b0, low_packet_valid}, 8'h00);
    #3 resetn = 1'b0;

    // good packet, no stall
    run_packet(8'h16, 5, 8'h00, -1);
    // bad parity
    run_packet(8'h16, 5, 8'h01, -1);
    // fifo full stall on payload byte 2, good parity
    run_packet(8'h16, 5, 8'h00, 2);
    // new valid header, then an invalid one that must replay it
    run_packet(8'h09, 2, 8'h00, -1);
    run_packet(8'h17, 3, 8'h00, -1);
    // stall plus bad parity
    run_packet(8'h0E, 4, 8'h80, 0);

    // mid-packet asynchronous reset
    detect_add = 1'b1; packet_valid = 1'b1; data_in = 8'h1A;
    tick();
    detect_add = 1'b0;
    lfd_state = 1'b1;
    tick();
    lfd_state = 1'b0;
    chk("dout_before_reset", dout, 8'h1A);
    ld_state = 1'b1; data_in = 8'h5C; fifo_full = 1'b1;
    #2 resetn = 1'b1;
    #1;
    chk("async_reset_dout", dout, 8'h00);
    chk("async_reset_err", {7'b0, err}, 8'h00);
    chk("async_reset_pdone", {7'b0, parity_done}, 8'h00);
    chk("async_reset_lpv", {7'b0, low_packet_valid}, 8'h00);
    tick();
    idle_inputs();
    #2 resetn = 1'b0;
    model_hdr = '0;
    // hdr_byte must be back to 0: an invalid header replays 0x00
    run_packet(8'h13, 3, 8'h00, 1);

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
